// File: rtl/a2d_spi_model.sv
// ----------------------------------------------------------------------------
// a2d_spi_model
//
// Synthesizable model of an 8-channel, 12-bit SPI A2D converter
// (ADC128S-style). It serves the left/right load-cell and battery readings to
// an SPI master. Each 16-bit frame returns the channel addressed in the
// previous frame (pipelined addressing). Channels other than the three mapped
// ones read as zero.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous, active-high reset
//   ld_cell_lft   [11:0] value returned for channel CH_LFT
//   ld_cell_rght  [11:0] value returned for channel CH_RGHT
//   batt_V        [11:0] value returned for channel CH_BATT
//   SS_n          SPI slave select, active low
//   SCLK          SPI serial clock (mode 0 or mode 3), each phase >= 4 clk
//   MOSI          SPI master-out data, sampled on SCLK rise
//   MISO          SPI slave-out data, changes on SCLK fall, 0 while deselected
// ----------------------------------------------------------------------------
module a2d_spi_model #(
  parameter logic [2:0] CH_LFT  = 3'd0,
  parameter logic [2:0] CH_RGHT = 3'd4,
  parameter logic [2:0] CH_BATT = 3'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] batt_V,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO
);

  // Two-flop synchronizers, plus a third stage on SS_n/SCLK for edge detect.
  logic ss_n_meta, ss_n_sync, ss_n_prev;
  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;

  // Only bits [13:11] of the address word are decoded, so the bit that would
  // sit above rx[14] is never needed and is not stored.
  logic [14:0] rx_shft;
  logic [15:0] tx_shft;
  logic [4:0]  bit_cnt;
  logic        seen_rise;
  logic [2:0]  chnl;
  logic [11:0] sel_value;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign ss_fall   =  ss_n_prev & ~ss_n_sync;
  assign ss_rise   = ~ss_n_prev &  ss_n_sync;
  assign sclk_rise =  sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync &  sclk_prev;

  // Channel decode of the value to be snapshotted at frame start.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_value = 12'h000;
    if (chnl == CH_LFT)
      sel_value = ld_cell_lft;
    else if (chnl == CH_RGHT)
      sel_value = ld_cell_rght;
    else if (chnl == CH_BATT)
      sel_value = batt_V;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_meta <= 1'b1;
      ss_n_sync <= 1'b1;
      ss_n_prev <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      rx_shft   <= '0;
      tx_shft   <= '0;
      bit_cnt   <= '0;
      seen_rise <= 1'b0;
      chnl      <= 3'd0;
    end else begin
      ss_n_meta <= SS_n;
      ss_n_sync <= ss_n_meta;
      ss_n_prev <= ss_n_sync;
      sclk_meta <= SCLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;

      if (ss_fall) begin
        // Snapshot here so mid-frame input changes cannot corrupt the frame.
        tx_shft   <= {4'b0000, sel_value};
        bit_cnt   <= '0;
        seen_rise <= 1'b0;
      end else if (!ss_n_sync) begin
        if (sclk_rise) begin
          rx_shft   <= {rx_shft[13:0], mosi_sync};
          if (bit_cnt != 5'd16)
            bit_cnt <= bit_cnt + 5'd1;
          seen_rise <= 1'b1;
        end else if (sclk_fall && seen_rise) begin
          // The idle-high fall that opens a mode-3 frame is skipped by seen_rise.
          tx_shft <= {tx_shft[14:0], 1'b0};
        end
      end

      // Only complete frames update the address; short frames are aborts.
      if (ss_rise && bit_cnt == 5'd16)
        chnl <= rx_shft[13:11];
    end
  end

  // Gated by the delayed select so the stale tx bit is never shown in the
  // cycle the new snapshot is being loaded.
  assign MISO = ~ss_n_prev & tx_shft[15];

endmodule

// File: tb/tb_a2d_spi_model.sv
// ----------------------------------------------------------------------------
// tb_a2d_spi_model
//
// Self-checking bench for a2d_spi_model. A bus-functional SPI master drives
// frames in mode 0 or mode 3; a reference model (current channel number and a
// channel-to-value lookup) predicts every 16-bit response.
// ----------------------------------------------------------------------------
module tb_a2d_spi_model;

  localparam int HALF = 8;  // clk cycles per SCLK phase

  localparam logic [2:0] M_LFT  = 3'd0;
  localparam logic [2:0] M_RGHT = 3'd4;
  localparam logic [2:0] M_BATT = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ld_cell_lft, ld_cell_rght, batt_V;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: channel that the next frame will return.
  logic [2:0] model_ch;

  a2d_spi_model dut (
    .clk          (clk),
    .rst          (rst),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .batt_V       (batt_V),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] value_of(input logic [2:0] ch);
    case (ch)
      M_LFT:   return ld_cell_lft;
      M_RGHT:  return ld_cell_rght;
      M_BATT:  return batt_V;
      default: return 12'h000;
    endcase
  endfunction

  // One SPI transaction. The last 16 bits shifted out on MOSI are the address
  // word; any leading extra bits are random. resp collects the first 16 MISO
  // bits, extra_nz flags a 1 seen on MISO after bit 16.
  task automatic frame(input logic [15:0] addr, input int nclk, input bit mode3,
                       input int chg_at, input logic [11:0] chg_val, input int rst_at,
                       output logic [15:0] resp, output bit extra_nz);
    int  lead;
    logic b;
    resp     = 16'h0000;
    extra_nz = 1'b0;
    lead     = (nclk > 16) ? nclk - 16 : 0;
    SCLK     = mode3;
    SS_n     = 1'b0;
    clks(HALF);
    for (int i = 0; i < nclk; i++) begin
      if (i == chg_at) ld_cell_lft = chg_val;
      if (i == rst_at) begin
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
      end
      if (i < lead) b = 1'($urandom);
      else          b = addr[15 - (i - lead)];
      if (mode3) SCLK = 1'b0;
      MOSI = b;
      clks(HALF);
      if (i < 16) resp[15 - i] = MISO;
      else if (MISO !== 1'b0) extra_nz = 1'b1;
      SCLK = 1'b1;
      clks(HALF);
      if (!mode3) SCLK = 1'b0;
    end
    clks(HALF);
    SS_n = 1'b1;
    clks(HALF);
  endtask

  // Frame predicted entirely by the reference model.
  task automatic run(input string tag, input logic [15:0] addr, input int nclk, input bit mode3);
    logic [15:0] exp, mask, resp;
    bit          extra_nz;
    exp  = {4'h0, value_of(model_ch)};
    mask = (nclk >= 16) ? 16'hFFFF : ~(16'hFFFF >> nclk);
    frame(addr, nclk, mode3, -1, 12'h000, -1, resp, extra_nz);
    check({tag, "_resp"}, resp & mask, exp & mask);
    if (nclk > 16) check({tag, "_extra0"}, {15'd0, extra_nz}, 16'h0000);
    check({tag, "_idle"}, {15'd0, MISO}, 16'h0000);
    if (nclk >= 16) model_ch = addr[13:11];
  endtask

  logic [15:0] r_resp;
  bit          r_extra;
  logic [15:0] r_exp;

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    ld_cell_lft = 12'h300; ld_cell_rght = 12'h350; batt_V = 12'h700;
    model_ch = 3'd0;
    clks(3);
    check("reset_miso", {15'd0, MISO}, 16'h0000);
    rst = 1'b0;
    clks(4);
    check("post_reset_miso", {15'd0, MISO}, 16'h0000);

    // Channel register resets to 0: first frames return ld_cell_lft.
    run("f_ch0_a", 16'h0000, 16, 1'b0);
    run("f_ch0_b", 16'h0000, 16, 1'b0);

    // Pipelined addressing across ch4, ch5, ch0.
    run("f_addr4", 16'h2000, 16, 1'b0);
    run("f_addr5", 16'h2800, 16, 1'b0);
    run("f_addr0", 16'h0000, 16, 1'b0);

    // Unmapped channel reads zero.
    run("f_addr2", 16'h1000, 16, 1'b0);
    run("f_unmap", 16'h0000, 16, 1'b0);

    // Aborted frame must not change the latched channel (ch4 stays).
    run("f_set4",  16'h2000, 16, 1'b0);
    run("f_abort", 16'h2800, 8,  1'b0);
    run("f_after_abort", 16'h0000, 16, 1'b0);

    // Mid-frame change of ld_cell_lft: current frame keeps the snapshot.
    r_exp = {4'h0, value_of(model_ch)};
    frame(16'h0000, 16, 1'b0, 5, 12'h000, -1, r_resp, r_extra);
    check("midchg_cur", r_resp, r_exp);
    model_ch = 3'd0;
    run("midchg_next", 16'h0000, 16, 1'b0);
    ld_cell_lft = 12'h300;

    // ch4 read in mode 0 and mode 3 must match.
    run("m0_set4",  16'h2000, 16, 1'b0);
    run("m3_read4", 16'h2000, 16, 1'b1);
    run("m0_read4", 16'h0000, 16, 1'b0);

    // SCLK/MOSI activity with SS_n high is ignored and MISO stays 0.
    run("idle_set5", 16'h2800, 16, 1'b0);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b1; MOSI = 1'($urandom); clks(HALF);
      SCLK = 1'b0; clks(HALF);
      check("idle_toggle_miso", {15'd0, MISO}, 16'h0000);
    end
    run("idle_after", 16'h0000, 16, 1'b0);

    // More than 16 SCLKs: extra MISO bits are 0, address from the last 16 bits.
    run("long_set5", 16'h2800, 19, 1'b1);
    run("long_read", 16'h0000, 16, 1'b0);

    // Reset mid-frame returns the channel register to 0.
    run("rst_set4", 16'h2000, 16, 1'b0);
    frame(16'h2800, 16, 1'b0, -1, 12'h000, 4, r_resp, r_extra);
    model_ch = 3'd0;
    run("rst_after", 16'h0000, 16, 1'b0);

    // Randomized frames against the reference model.
    for (int k = 0; k < 20; k++) begin
      logic [15:0] a;
      int          n;
      ld_cell_lft  = 12'($urandom);
      ld_cell_rght = 12'($urandom);
      batt_V       = 12'($urandom);
      a = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 20));
      run($sformatf("rnd%0d", k), a, n, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
